imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle core fetches from.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word count, then that many 16-bit instruction words, high byte first.
- Assembles each pair of bytes into a word and issues one write per word to the instruction memory write port.
- Holds the core in reset until the load completes cleanly.

Parameters:
- MEM_DEPTH, 64: number of 16-bit words in instruction memory; the maximum legal word count.
- ADDR_STRIDE, 4: byte-address increment per word; matches the core's PC+4 stepping.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  16  byte address of the word being written.
- imem_wd  output  16  word being written.
- cpu_rst_hold  output  1  keeps the core in reset while high.
- busy  output  1  load in progress.
- done  output  1  sticky; last load succeeded.
- error  output  1  sticky; last load failed.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wd=0.
  - cpu_rst_hold=1, busy=0, done=0, error=0.
  - Internal word counter, length and byte latch all 0.
- Reset asserted mid-load aborts immediately. Words already written stay in memory. cpu_rst_hold stays 1.
- A byte transfers on a rising edge with in_valid&&in_ready. in_ready is combinational from state only: 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK; 0 elsewhere.
- States:
  - IDLE/DONE/ERR: start -> LEN_HI. On that edge clear done/error, set busy=1, cpu_rst_hold=1, word counter=0.
  - LEN_HI: transfer latches len[15:8] -> LEN_LO.
  - LEN_LO: transfer latches len[7:0], then one of:
    - full len>MEM_DEPTH -> ERR.
    - len==0 -> CHK if LOADER_CHECKSUM_EN is defined, else DONE.
    - otherwise -> DATA_HI.
  - DATA_HI: transfer latches the high byte -> DATA_LO.
  - DATA_LO: transfer produces a write on the next cycle: imem_we=1 for exactly one cycle, imem_wd={hi,byte}, imem_addr=counter*ADDR_STRIDE (16-bit, truncating). Counter then increments. Next state: counter+1==len -> CHK (if LOADER_CHECKSUM_EN is defined) or DONE; else DATA_HI.
  - Entering DONE: busy=0, done=1, cpu_rst_hold=0.
  - Entering ERR: busy=0, error=1, cpu_rst_hold=1.
- Throughput: one byte per cycle; the write pipeline never back-pressures. A back-to-back stream of N words takes 2+2N transfer cycles, plus 1 cycle for the final write.
- in_valid low stalls in place with no timeout. Bytes presented while in_ready=0 are ignored.
- start while busy is ignored. start in the same cycle as a final transfer is ignored.
- imem_addr and imem_wd hold their last values when imem_we=0.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of every transferred byte, length bytes included, is kept; it is cleared on start.
  - After the last word, CHK expects one trailing byte. Equal to the XOR -> DONE; otherwise -> ERR.
  - The CHK state exists only when the macro is defined.
- Undefined: no trailing byte and no CHK state. The only error is len>MEM_DEPTH.

Decomposition:
- Shared package (loader_pkg): state encoding constants (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR; 3 bits) and default MEM_DEPTH/ADDR_STRIDE constants.
- One natural sub-module, byte_pair_assembler: latches the high byte and emits a word plus a one-cycle valid on the low byte.
- FSM, counters and checksum stay in imem_loader.

Test Plan:
- Reset held with garbage stream -> in_ready=0, imem_we=0, cpu_rst_hold=1, done=0, error=0.
- start; bytes 00 02 12 34 AB CD (macro off) -> writes (0x0000,0x1234), (0x0004,0xABCD); done=1, cpu_rst_hold=0 one cycle after the last write.
- Same stream with in_valid toggled every other cycle -> identical writes, exactly 2 imem_we pulses, no duplicates.
- start; len 00 41 (65 > MEM_DEPTH=64) -> ERR right after the 2nd byte, no imem_we, error=1, cpu_rst_hold=1.
- Macro on: 00 01 12 34 then checksum 0x27 -> done=1. Checksum 0x28 -> error=1, but the write (0x0000,0x1234) still occurred.
- rst pulsed after the 3rd byte of a load -> all outputs at reset values; a following start with 00 00 (macro off) -> done=1 with no writes.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state).
package loader_pkg;

  localparam int unsigned DEF_MEM_DEPTH   = 64;
  localparam int unsigned DEF_ADDR_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK     = 3'd5,
`endif
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // States in which the loader consumes stream bytes.
  function automatic logic ready_in_state(input state_t s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: ready_in_state = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:                                       ready_in_state = 1'b1;
`endif
      default:                                      ready_in_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Joins a high byte and a following low byte into one 16-bit word with a
// one-cycle valid pulse registered on the low-byte transfer.
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_load,
  input  logic        lo_load,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0] hi_q;

  // Latch the high byte; publish the word (held until the next pair).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= lo_load;
      if (hi_load) hi_q <= byte_in;
      if (lo_load) word <= {hi_q, byte_in};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a 16-bit word count and that
// many big-endian 16-bit words over a byte handshake, writes them to the
// instruction memory and releases the core from reset on success.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int unsigned ADDR_STRIDE = DEF_ADDR_STRIDE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wd,
  output logic        cpu_rst_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MAX_LEN = 16'(MEM_DEPTH);
  localparam logic [15:0] STRIDE  = 16'(ADDR_STRIDE);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = ST_CHK;
`else
  localparam state_t TAIL = ST_DONE;
`endif

  state_t      state, state_n;
  logic        xfer, launch, hi_load, lo_load;
  logic [15:0] len_q, cnt_q, len_full;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign in_ready = ready_in_state(state);
  assign xfer     = in_valid && in_ready;
  assign len_full = {len_q[15:8], in_data};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state decode and byte-routing strobes.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    hi_load = 1'b0;
    lo_load = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_n = ST_LEN_HI;
          launch  = 1'b1;
        end
      end
      ST_LEN_HI: if (xfer) state_n = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_full > MAX_LEN)   state_n = ST_ERR;
          else if (len_full == '0)  state_n = TAIL;
          else                      state_n = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          hi_load = 1'b1;
          state_n = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          lo_load = 1'b1;
          state_n = (cnt_q + 16'd1 == len_q) ? TAIL : ST_DATA_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: if (xfer) state_n = (in_data == csum_q) ? ST_DONE : ST_ERR;
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // Length, word counter, write address, checksum and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      cnt_q        <= '0;
      imem_addr    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_rst_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      if (launch) begin
        cnt_q        <= '0;
        busy         <= 1'b1;
        done         <= 1'b0;
        error        <= 1'b0;
        cpu_rst_hold <= 1'b1;
      end
      if (xfer && state == ST_LEN_HI) len_q[15:8] <= in_data;
      if (xfer && state == ST_LEN_LO) len_q[7:0]  <= in_data;
      if (lo_load) begin
        imem_addr <= cnt_q * STRIDE;
        cnt_q     <= cnt_q + 16'd1;
      end
`ifdef LOADER_CHECKSUM_EN
      if (launch)    csum_q <= '0;
      else if (xfer) csum_q <= csum_q ^ in_data;
`endif
      if (state_n == ST_DONE && state != ST_DONE) begin
        busy         <= 1'b0;
        done         <= 1'b1;
        cpu_rst_hold <= 1'b0;
      end
      if (state_n == ST_ERR && state != ST_ERR) begin
        busy         <= 1'b0;
        error        <= 1'b1;
        cpu_rst_hold <= 1'b1;
      end
    end
  end

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .hi_load    (hi_load),
    .lo_load    (lo_load),
    .byte_in    (in_data),
    .word       (imem_wd),
    .word_valid (imem_we)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: hand-written corner sequences plus a
// table of randomized loads compared against a word-list reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, cpu_rst_hold, busy, done, error;
  logic [15:0] imem_addr, imem_wd;

  imem_loader #(.MEM_DEPTH(64), .ADDR_STRIDE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .cpu_rst_hold(cpu_rst_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every memory write as {addr, data}.
  logic [31:0] wr_q[$];
  always @(negedge clk) if (imem_we) wr_q.push_back({imem_addr, imem_wd});

  int unsigned total_cnt = 0, pass_cnt = 0, stalls = 0;
  logic [15:0] wbuf [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Present one byte after 'gap' idle cycles; random start pulses must be ignored.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned guard;
    for (int unsigned g = 0; g < gap; g++) begin
      in_valid = 1'b0; in_data = 8'($urandom); start = 1'($urandom); tick();
    end
    in_valid = 1'b1; in_data = b; start = 1'($urandom);
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; stalls++; end
    if (!in_ready) check("byte accept timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; start = 1'b0;
  endtask

  // Full load of len words from wbuf; the model expects word i at byte address 4*i.
  task automatic run_load(input logic [15:0] len, input int unsigned gap, input bit bad_chk,
                          input bit exp_done, input bit exp_err, input string tag);
    int unsigned base, nexp;
    logic [7:0] x;
    base = wr_q.size(); stalls = 0; x = 8'h00;
    nexp = (len <= 16'd64) ? 32'(len) : 0;
    do_start();
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " hold during load"}, 32'(cpu_rst_hold), 32'd1);
    send_byte(len[15:8], gap); x ^= len[15:8];
    send_byte(len[7:0], gap);  x ^= len[7:0];
    for (int unsigned i = 0; i < nexp; i++) begin
      send_byte(wbuf[i][15:8], gap); x ^= wbuf[i][15:8];
      send_byte(wbuf[i][7:0], gap);  x ^= wbuf[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    if (len <= 16'd64) send_byte(bad_chk ? (x ^ 8'h0F) : x, gap);
`else
    if (nexp > 0) check({tag, " write after last byte"}, 32'(imem_we), 32'd1);
    if (bad_chk) x = 8'h00;
`endif
    tick();
    check({tag, " done"}, 32'(done), 32'(exp_done));
    check({tag, " error"}, 32'(error), 32'(exp_err));
    check({tag, " hold"}, 32'(cpu_rst_hold), 32'(!exp_done));
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " ready end"}, 32'(in_ready), 32'd0);
    check({tag, " we end"}, 32'(imem_we), 32'd0);
    check({tag, " write count"}, wr_q.size() - base, nexp);
    if (gap == 0) check({tag, " no backpressure"}, stalls, 0);
    for (int unsigned i = 0; i < nexp; i++)
      if (base + i < wr_q.size())
        check($sformatf("%s wr%0d", tag, i), wr_q[base + i], {16'(i * 4), wbuf[i]});
  endtask

  typedef struct {
    logic [15:0] len;
    int unsigned gap;
    bit          bad;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{16'd1,      0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{16'd64,     0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'd7,      1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'd5,      3, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'd65,     0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'hFFFF,   1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{16'h0100,   0, 1'b0, 1'b0, 1'b1};
`ifdef LOADER_CHECKSUM_EN
    tbl[7] = '{16'd3,      0, 1'b1, 1'b0, 1'b1};
`else
    tbl[7] = '{16'd3,      0, 1'b1, 1'b1, 1'b0};
`endif

    // Reset held while garbage is driven.
    for (int unsigned c = 0; c < 4; c++) begin
      in_valid = 1'($urandom); in_data = 8'($urandom); start = 1'($urandom);
      tick();
      check("rst in_ready", 32'(in_ready), 32'd0);
      check("rst imem_we", 32'(imem_we), 32'd0);
    end
    check("rst hold", 32'(cpu_rst_hold), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst addr/wd", {imem_addr, imem_wd}, 32'd0);
    in_valid = 1'b0; start = 1'b0;
    rst = 1'b0;
    tick();
    check("idle in_ready", 32'(in_ready), 32'd0);

    // Two-word load, back to back and with in_valid toggling.
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    run_load(16'd2, 0, 1'b0, 1'b1, 1'b0, "two");
    check("addr/wd hold", {imem_addr, imem_wd}, 32'h0004ABCD);
    run_load(16'd2, 1, 1'b0, 1'b1, 1'b0, "two toggled");

    // Oversize length: error right after the second length byte.
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h41, 0);
    check("oversize error", 32'(error), 32'd1);
    check("oversize hold", 32'(cpu_rst_hold), 32'd1);
    check("oversize ready", 32'(in_ready), 32'd0);
    tick();
    check("oversize no write", 32'(imem_we), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Good and bad checksum on a one-word load; the write happens either way.
    wbuf[0] = 16'h1234;
    run_load(16'd1, 0, 1'b0, 1'b1, 1'b0, "chk good");
    run_load(16'd1, 0, 1'b1, 1'b0, 1'b1, "chk bad");
`endif

    // Reset pulse mid-load, then an empty load.
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst ready", 32'(in_ready), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst hold", 32'(cpu_rst_hold), 32'd1);
    check("midrst flags", {30'd0, done, error}, 32'd0);
    tick();
    rst = 1'b0;
    check("midrst addr/wd", {imem_addr, imem_wd}, 32'd0);
    check("midrst we", 32'(imem_we), 32'd0);
    run_load(16'd0, 0, 1'b0, 1'b1, 1'b0, "empty");

    // Randomized loads from the table.
    for (int unsigned r = 0; r < 8; r++) begin
      for (int unsigned i = 0; i < 64; i++) wbuf[i] = 16'($urandom);
      run_load(tbl[r].len, tbl[r].gap, tbl[r].bad, tbl[r].exp_done, tbl[r].exp_err,
               $sformatf("row%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
